// File: rtl/random_lca_stream_pkg.sv
// Shared types and constants for the linear cellular-automaton random stream.
// Holds the FSM encoding, rule-mode encodings and the scheduled rule table.
package random_lca_stream_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2
  } state_e;

  localparam logic [1:0] ModeFixed     = 2'b00;
  localparam logic [1:0] ModeSched     = 2'b01;
  localparam logic [1:0] ModeExt       = 2'b10;
  localparam logic [1:0] ModeSchedSkip = 2'b11;

  localparam logic [7:0] Rule30  = 8'd30;
  localparam logic [7:0] Rule60  = 8'd60;
  localparam logic [7:0] Rule90  = 8'd90;
  localparam logic [7:0] Rule150 = 8'd150;

  localparam int unsigned WarmW = 8;
  localparam int unsigned CntW  = 6;

  function automatic logic [7:0] sched_rule(input logic [1:0] sel);
    logic [7:0] r;
    case (sel)
      2'd0:    r = Rule30;
      2'd1:    r = Rule60;
      2'd2:    r = Rule90;
      default: r = Rule150;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ca_rule_step.sv
// One combinational step of an elementary cellular automaton on a ring of Width cells.
module ca_rule_step #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] state,
  input  logic [7:0]       rule,
  output logic [Width-1:0] next_state
);

  for (genvar i = 0; i < Width; i++) begin : g_cell
    localparam int unsigned Left  = (i + 1) % Width;
    localparam int unsigned Right = (i + Width - 1) % Width;
    assign next_state[i] = rule[{state[Left], state[i], state[Right]}];
  end

endmodule

// File: rtl/random_lca_stream.sv
// Seedable cellular-automaton random word generator with warmup and a
// valid/ready output stream.
module random_lca_stream
  import random_lca_stream_pkg::*;
#(
  parameter int unsigned Width  = 8,
  parameter int unsigned Warmup = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [Width-1:0] seed,
  output logic             seed_ready,
  input  logic [1:0]       mode,
  input  logic [7:0]       rule_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic [Width-1:0] ca_state,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [Width-1:0]  ca_q, ca_d;
  logic [Width-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WarmW-1:0]  warm_q, warm_d;

  logic [7:0]        rule_sel;
  logic [Width-1:0]  ca_next;
  logic              par;
  logic              accept;
  logic              advance;
  logic              sched;

  always_comb begin
    case (mode)
      ModeFixed: rule_sel = Rule30;
      ModeExt:   rule_sel = rule_in;
      default:   rule_sel = sched_rule(cnt_q[CntW-1 -: 2]);
    endcase
  end

  ca_rule_step #(
    .Width(Width)
  ) u_step (
    .state     (ca_q),
    .rule      (rule_sel),
    .next_state(ca_next)
  );

  assign par        = ^ca_next;
  assign sched      = (mode == ModeSched) || (mode == ModeSchedSkip);
  assign seed_ready = (state_q != StWarmup);
  assign busy       = (state_q == StWarmup);
  assign accept     = seed_valid && seed_ready;
  assign advance    = (state_q == StRun) && (!valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    ca_d    = ca_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    if (accept) begin
      // An all-zero ring is a fixed point for rule 30, so force a live cell.
      state_d = StWarmup;
      ca_d    = (seed == '0) ? {{(Width-1){1'b0}}, 1'b1} : seed;
      data_d  = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      warm_d  = WarmW'(Warmup);
    end else begin
      case (state_q)
        StWarmup: begin
          if (warm_q == '0) begin
            state_d = StRun;
          end else begin
            ca_d   = ca_next;
            warm_d = warm_q - WarmW'(1);
          end
        end
        StRun: begin
          if (advance) begin
            ca_d  = ca_next;
            cnt_d = cnt_q + CntW'(1) + (sched ? CntW'(par) : '0);
            if (!((mode == ModeSchedSkip) && par)) begin
              data_d  = {data_q[Width-2:0], data_q[Width-1]} ^ ca_next;
              valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ca_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      ca_q    <= ca_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ca_state  = ca_q;

endmodule

// File: tb/tb_random_lca_stream.sv
// Self-checking bench for random_lca_stream: a step-count based reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_random_lca_stream;

  localparam int W  = 8;
  localparam int WU = 16;

  logic         clk;
  logic         rst;
  logic         seed_valid;
  logic [W-1:0] seed;
  logic         seed_ready;
  logic [1:0]   mode;
  logic [7:0]   rule_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [W-1:0] ca_state;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  random_lca_stream #(
    .Width (W),
    .Warmup(WU)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_valid(seed_valid),
    .seed      (seed),
    .seed_ready(seed_ready),
    .mode      (mode),
    .rule_in   (rule_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ca_state  (ca_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the generator is described by how many edges have passed
  // since the last seed was taken, not by an FSM.
  bit         m_seeded;
  int         m_age;
  logic [7:0] m_ca;
  logic [7:0] m_data;
  bit         m_valid;
  int         m_cnt;

  function automatic logic [7:0] m_step(input logic [7:0] s, input logic [7:0] r);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = 4 * int'(s[(i + 1) % 8]) + 2 * int'(s[i]) + int'(s[(i + 7) % 8]);
      n[i] = r[idx];
    end
    return n;
  endfunction

  function automatic logic [7:0] m_rule(input logic [1:0] md, input logic [7:0] ext, input int cnt);
    logic [7:0] tbl [4];
    tbl[0] = 8'd30; tbl[1] = 8'd60; tbl[2] = 8'd90; tbl[3] = 8'd150;
    if (md == 2'd0) return 8'd30;
    if (md == 2'd2) return ext;
    return tbl[cnt / 16];
  endfunction

  task automatic model_update();
    logic [7:0] nxt;
    bit in_warm;
    bit par;
    if (!rst) begin
      m_seeded = 0; m_age = 0; m_ca = 0; m_data = 0; m_valid = 0; m_cnt = 0;
      return;
    end
    in_warm = m_seeded && (m_age <= WU);
    if (seed_valid && !in_warm) begin
      m_ca     = (seed == 0) ? 8'h01 : seed;
      m_data   = 0;
      m_valid  = 0;
      m_cnt    = 0;
      m_seeded = 1;
      m_age    = 0;
    end else if (m_seeded) begin
      if (m_age < WU) begin
        m_ca = m_step(m_ca, m_rule(mode, rule_in, m_cnt));
      end else if (m_age > WU && (!m_valid || out_ready)) begin
        nxt   = m_step(m_ca, m_rule(mode, rule_in, m_cnt));
        par   = ^nxt;
        m_cnt = (m_cnt + 1 + ((mode[0]) ? int'(par) : 0)) % 64;
        if (!(mode == 2'd3 && par)) begin
          m_data  = ((m_data << 1) | (m_data >> 7)) ^ nxt;
          m_valid = 1;
        end
        m_ca = nxt;
      end
      if (m_age <= WU) m_age++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_update();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("ca_state", 64'(ca_state), 64'(m_ca));
      chk("busy", 64'(busy), 64'(m_seeded && m_age <= WU));
      chk("seed_ready", 64'(seed_ready), 64'(!(m_seeded && m_age <= WU)));
    end
  end

  task automatic accept_seed(input logic [W-1:0] s);
    @(posedge clk); #1;
    seed_valid = 1'b1;
    seed       = s;
    @(posedge clk); #1;
    seed_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_ca"}, 64'(ca_state), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_seed_ready"}, 64'(seed_ready), 64'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b0; seed_valid = 1'b0; seed = '0; mode = 2'd0; rule_in = 8'd0; out_ready = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1;

    // Rule 30 from a single live cell: 01 -> 83 -> 46.
    out_ready = 1'b1;
    accept_seed(8'h01);
    @(negedge clk);
    chk("load_ca", 64'(ca_state), 64'h01);
    chk("load_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("step1_ca", 64'(ca_state), 64'h83);
    chk("step1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("step2_ca", 64'(ca_state), 64'h46);
    repeat (20) @(posedge clk);

    // Zero seed substitution, first-valid latency, then continuous output.
    accept_seed(8'h00);
    @(negedge clk);
    chk("zero_seed_ca", 64'(ca_state), 64'h01);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk("first_valid_latency", 64'(lat), 64'd18);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      chk("ca_nonzero", 64'(ca_state != 0), 64'd1);
      chk("valid_every_cycle", 64'(out_valid), 64'd1);
    end

    // Back-pressure for 10 cycles, then release.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (5) @(posedge clk);

    // External rule with a mid-stream change and irregular back-pressure.
    #1 mode = 2'd2; rule_in = 8'd110;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      out_ready = (n % 3 != 0);
      if (n == 15) rule_in = 8'd45;
    end

    // Scheduled rules over a full counter wrap.
    out_ready = 1'b1;
    mode = 2'd1;
    repeat (90) @(posedge clk);

    // Scheduled with parity skip and intermittent back-pressure.
    #1 mode = 2'd3;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      out_ready = (n % 4 != 1);
    end

    // Reseed in RUN while a word is pending discards it.
    mode = 2'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    accept_seed(8'hA5);
    chk("reseed_drop_valid", 64'(out_valid), 64'd0);
    chk("reseed_busy", 64'(busy), 64'd1);
    chk("reseed_ca", 64'(ca_state), 64'hA5);
    out_ready = 1'b1;
    repeat (25) @(posedge clk);

    // Asynchronous reset pulse between clock edges.
    #2 rst = 1'b0;
    #1;
    check_reset_vals("async_reset");
    #1 rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("idle_no_valid", 64'(out_valid), 64'd0);
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/random_lca_stream.md
RANDOM_LCA_STREAM -- requirements
Module: random_lca_stream

Interface
REQ-001 SHALL have parameter Width, default 8, meaning CA cell count and output width (legal 4..64).
REQ-002 SHALL have parameter Warmup, default 16, meaning CA steps discarded after each seed load (legal 1..255).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port seed_valid  input  1  seed offer.
REQ-006 SHALL have port seed  input  Width  seed value.
REQ-007 SHALL have port seed_ready  output  1  seed acceptance allowed.
REQ-008 SHALL have port mode  input  2  rule mode: 00 fixed rule 30; 01 scheduled; 10 external; 11 scheduled, parity-skip.
REQ-009 SHALL have port rule_in  input  8  external rule, used in mode 10.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts word.
REQ-012 SHALL have port out_data  output  Width  random word.
REQ-013 SHALL have port ca_state  output  Width  current CA state, debug.
REQ-014 SHALL have port busy  output  1  high in WARMUP.

Function
REQ-015 SHALL implement states IDLE, WARMUP, RUN; reset enters IDLE.
REQ-016 SHALL drive seed_ready high in IDLE and RUN, low in WARMUP.
REQ-017 On seed_valid && seed_ready: load CA state with seed (all-zero seed replaced by 1), clear out_data, counter and out_valid, load warm count with Warmup, enter WARMUP.
REQ-018 CA step: cyclic boundary; cell i next = rule[{s[i+1], s[i], s[i-1]}], indices mod Width.
REQ-019 Rule select: mode 00 -> 8'd30; mode 10 -> rule_in; modes 01/11 -> counter[5:4] = 0,1,2,3 selects 30, 60, 90, 150.
REQ-020 WARMUP: step CA every cycle, decrement warm count; after count reaches 0, enter RUN next cycle; out_data and out_valid untouched.
REQ-021 RUN: advance when out_valid==0 or out_ready==1; advance = CA step, out_data <= rotate-left-1(out_data) XOR next CA state, out_valid <= 1.
REQ-022 Counter: 6 bits, wraps mod 64; each advance adds 1, plus parity(next state) in modes 01/11; mode 11 additionally suppresses the out_data update (out_valid unchanged) on advances where parity is 1.
REQ-023 First out_valid SHALL assert exactly Warmup+2 cycles after the seed-accept edge, given out_ready irrelevant.
REQ-024 With out_valid=1 and out_ready=0, out_data, ca_state and counter SHALL hold stable.
REQ-025 Seed accepted in RUN SHALL drop out_valid on the next edge, discarding any unconsumed word.
REQ-026 Mode or rule_in changes SHALL take effect on the next step; no state restart.
REQ-027 IDLE: no stepping, out_valid=0.

Reset
REQ-028 Reset values: state IDLE, CA state 0, out_data 0, out_valid 0, counter 0, warm count 0, busy 0, seed_ready 1 (comb of IDLE).
REQ-029 Reset assertion mid-WARMUP or mid-RUN SHALL clear all registers immediately, without waiting for clk.

Structure
REQ-030 Shared package SHALL hold state encoding, mode encodings and the four scheduled rule constants (30, 60, 90, 150).
REQ-031 One sub-module ca_rule_step SHALL compute the combinational one-step CA next state from (state, rule), parametrised by Width.

Verification
REQ-032 Width=8, Warmup=1, mode 00, seed 8'h01 accepted -> ca_state 8'h83 one cycle later, busy high that cycle.
REQ-033 Seed 8'h00 accepted -> ca_state after load reads 8'h01, never all-zero during 100 steps in mode 00.
REQ-034 Warmup=16, out_ready=1 held -> out_valid first high 18 cycles after accept, then high every cycle.
REQ-035 out_ready=0 for 10 cycles with out_valid=1 -> out_data, ca_state constant; release -> new word next cycle.
REQ-036 rst low mid-RUN for a partial cycle -> all outputs at reset values immediately, seed_ready=1.
REQ-037 Mode 01, 64+ advances -> counter wraps, rule sequence follows counter[5:4], matches reference model bit-exactly.
